// File: rtl/uart_pkg.sv
// Shared types and constants for the UART command assembler.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT_HI = 2'd1,
    WAIT_LO = 2'd2
  } asm_state_t;

  localparam int PKT_BYTES = 3;

endpackage

// File: rtl/uart_cmd_assembler_gap_timer.sv
// Inter-byte gap timer: counts idle cycles while enabled and flags the terminal count.
module uart_gap_timer #(
  parameter int TIMEOUT_CYC = 100000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output logic expire
);

  localparam int CW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CW-1:0] TERM = CW'(TIMEOUT_CYC - 1);

  logic [CW-1:0] count;

  assign expire = en && (count == TERM);

  // Restarting at the terminal count keeps the counter from ever wrapping.
  always_ff @(posedge clk) begin
    if (!rst_n || clr || !en || expire) begin
      count <= '0;
    end else begin
      count <= count + CW'(1);
    end
  end

endmodule

// File: rtl/uart_cmd_assembler.sv
// Collects opcode/data-high/data-low bytes from the UART receiver into one command word,
// discarding partial packets when the inter-byte gap runs out.
module uart_cmd_assembler
  import uart_pkg::*;
#(
  parameter int TIMEOUT_CYC = 100000
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           rx_rdy,
  input  logic [7:0]                     rx_data,
  output logic                           clr_rx_rdy,
  input  logic                           clr_cmd_rdy,
  output logic                           cmd_rdy,
  output logic [7:0]                     cmd_op,
  output logic [8*(PKT_BYTES-1)-1:0]     cmd_data,
  output logic                           timeout_err
);

  localparam int DATA_W = 8 * (PKT_BYTES - 1);

  asm_state_t state_q, state_d;
  logic       rx_rdy_q;
  logic       byte_evt;
  logic       waiting;
  logic       gap_expire;
  logic       load_op, load_hi, load_lo, drop;

  // rx_rdy stays high until the receiver sees our clear, so only its rising edge counts.
  assign byte_evt = rx_rdy & ~rx_rdy_q;
  assign waiting  = (state_q != IDLE);

  uart_gap_timer #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_gap_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (waiting),
    .clr   (byte_evt),
    .expire(gap_expire)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_rdy_q   <= 1'b0;
      clr_rx_rdy <= 1'b0;
    end else begin
      rx_rdy_q   <= rx_rdy;
      clr_rx_rdy <= byte_evt;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    load_op = 1'b0;
    load_hi = 1'b0;
    load_lo = 1'b0;
    drop    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (byte_evt) begin
          load_op = 1'b1;
          state_d = WAIT_HI;
        end
      end
      WAIT_HI: begin
        if (byte_evt) begin
          load_hi = 1'b1;
          state_d = WAIT_LO;
        end else if (gap_expire) begin
          drop    = 1'b1;
          state_d = IDLE;
        end
      end
      WAIT_LO: begin
        if (byte_evt) begin
          load_lo = 1'b1;
          state_d = IDLE;
        end else if (gap_expire) begin
          drop    = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // The error pulse coincides with the terminal-count cycle; reset suppresses it.
  assign timeout_err = drop & rst_n;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cmd_op   <= '0;
      cmd_data <= '0;
      cmd_rdy  <= 1'b0;
    end else begin
      if (load_op) cmd_op <= rx_data;
      if (load_hi) cmd_data[DATA_W-1 -: 8] <= rx_data;
      if (load_lo) cmd_data[7:0] <= rx_data;
      if (load_lo) begin
        cmd_rdy <= 1'b1;
      end else if (load_op || clr_cmd_rdy) begin
        cmd_rdy <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_cmd_assembler.sv
// Directed self-checking bench for uart_cmd_assembler (default timeout and a 50-cycle timeout instance).
module tb_uart_cmd_assembler;
  import uart_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        rx_rdy;
  logic [7:0]  rx_data;
  logic        clr_cmd_rdy;

  logic        clr_rx_rdy, cmd_rdy, timeout_err;
  logic [7:0]  cmd_op;
  logic [15:0] cmd_data;

  logic        clr_rx_rdy_s, cmd_rdy_s, timeout_err_s;
  logic [7:0]  cmd_op_s;
  logic [15:0] cmd_data_s;

  int errors = 0;
  int checks = 0;
  int pulses_s = 0;

  uart_cmd_assembler #(.TIMEOUT_CYC(50)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx_rdy     (rx_rdy),
    .rx_data    (rx_data),
    .clr_rx_rdy (clr_rx_rdy),
    .clr_cmd_rdy(clr_cmd_rdy),
    .cmd_rdy    (cmd_rdy),
    .cmd_op     (cmd_op),
    .cmd_data   (cmd_data),
    .timeout_err(timeout_err)
  );

  uart_cmd_assembler dut_slow (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx_rdy     (rx_rdy),
    .rx_data    (rx_data),
    .clr_rx_rdy (clr_rx_rdy_s),
    .clr_cmd_rdy(clr_cmd_rdy),
    .cmd_rdy    (cmd_rdy_s),
    .cmd_op     (cmd_op_s),
    .cmd_data   (cmd_data_s),
    .timeout_err(timeout_err_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (clr_rx_rdy_s) pulses_s++;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic startByte(input logic [7:0] b);
    rx_rdy  = 1'b1;
    rx_data = b;
    tick();
  endtask

  // Receiver drops rx_rdy a cycle after our clear, then stays low one cycle.
  task automatic endByte();
    tick();
    rx_rdy = 1'b0;
    tick();
  endtask

  task automatic applyStimulus(input logic [7:0] b);
    startByte(b);
    endByte();
  endtask

  task automatic doReset();
    rst_n       = 1'b0;
    rx_rdy      = 1'b0;
    rx_data     = 8'h00;
    clr_cmd_rdy = 1'b0;
    ticks(2);
    rst_n = 1'b1;
  endtask

  initial begin
    int first, highs, any_rdy, base;

    // Reset with rx_rdy already high
    rst_n = 1'b0; rx_rdy = 1'b1; rx_data = 8'h99; clr_cmd_rdy = 1'b0;
    ticks(2);
    checkOutput("rst_clr_rx_rdy", 32'(clr_rx_rdy), 32'd0);
    checkOutput("rst_cmd_rdy", 32'(cmd_rdy), 32'd0);
    checkOutput("rst_cmd_op", 32'(cmd_op), 32'h0);
    checkOutput("rst_cmd_data", 32'(cmd_data), 32'h0);
    checkOutput("rst_timeout_err", 32'(timeout_err), 32'd0);
    checkOutput("rst_state", 32'(dut.state_q), 32'(IDLE));
    rst_n = 1'b1;
    checkOutput("rst_release_no_capture", 32'(cmd_op), 32'h0);
    tick();
    checkOutput("rst_first_capture_op", 32'(cmd_op), 32'h99);
    checkOutput("rst_first_capture_clr", 32'(clr_rx_rdy), 32'd1);
    rx_rdy = 1'b0;
    doReset();

    // Single packet at 19200-baud spacing on the default-timeout instance
    base = pulses_s;
    applyStimulus(8'hA5);
    ticks(26037);
    applyStimulus(8'h12);
    ticks(26037);
    checkOutput("slow_rdy_before_last", 32'(cmd_rdy_s), 32'd0);
    startByte(8'h34);
    checkOutput("slow_cmd_rdy", 32'(cmd_rdy_s), 32'd1);
    checkOutput("slow_cmd_op", 32'(cmd_op_s), 32'hA5);
    checkOutput("slow_cmd_data", 32'(cmd_data_s), 32'h1234);
    checkOutput("slow_no_timeout", 32'(timeout_err_s), 32'd0);
    endByte();
    tick();
    checkOutput("slow_clr_pulses", 32'(pulses_s - base), 32'd3);
    doReset();

    // Handshake: clear, then clear colliding with set
    applyStimulus(8'h01);
    applyStimulus(8'h02);
    applyStimulus(8'h03);
    checkOutput("hs_rdy_set", 32'(cmd_rdy), 32'd1);
    clr_cmd_rdy = 1'b1;
    tick();
    clr_cmd_rdy = 1'b0;
    checkOutput("hs_rdy_cleared", 32'(cmd_rdy), 32'd0);
    checkOutput("hs_op_kept", 32'(cmd_op), 32'h01);
    checkOutput("hs_data_kept", 32'(cmd_data), 32'h0203);
    applyStimulus(8'h04);
    applyStimulus(8'h05);
    rx_rdy = 1'b1; rx_data = 8'h06; clr_cmd_rdy = 1'b1;
    tick();
    clr_cmd_rdy = 1'b0;
    checkOutput("hs_set_wins", 32'(cmd_rdy), 32'd1);
    checkOutput("hs_set_wins_data", 32'(cmd_data), 32'h0506);
    endByte();
    checkOutput("hs_rdy_holds", 32'(cmd_rdy), 32'd1);

    // Back-to-back: new opcode while command pending
    startByte(8'h55);
    checkOutput("b2b_rdy_dropped", 32'(cmd_rdy), 32'd0);
    checkOutput("b2b_op_new", 32'(cmd_op), 32'h55);
    checkOutput("b2b_data_untouched", 32'(cmd_data), 32'h0506);
    endByte();
    applyStimulus(8'h66);
    applyStimulus(8'h77);
    checkOutput("b2b_cmd", 32'({cmd_rdy, cmd_op, cmd_data}), 32'h1_55_6677);
    doReset();

    // Timeout after two bytes
    applyStimulus(8'h01);
    startByte(8'h02);
    endByte();
    first = -1; highs = 0; any_rdy = 0;
    for (int cyc = 3; cyc < 120; cyc++) begin
      if (timeout_err) begin
        if (first < 0) first = cyc;
        highs++;
      end
      if (cmd_rdy) any_rdy = 1;
      tick();
    end
    checkOutput("to_pulse_cycle", 32'(first), 32'd50);
    checkOutput("to_pulse_width", 32'(highs), 32'd1);
    checkOutput("to_no_cmd_rdy", 32'(any_rdy), 32'd0);
    checkOutput("to_state_idle", 32'(dut.state_q), 32'(IDLE));
    applyStimulus(8'h07);
    applyStimulus(8'h00);
    applyStimulus(8'hFF);
    checkOutput("to_next_cmd", 32'({cmd_rdy, cmd_op, cmd_data}), 32'h1_07_00FF);
    doReset();

    // Byte arriving exactly on the terminal-count cycle
    applyStimulus(8'h0A);
    startByte(8'h0B);
    endByte();
    ticks(47);
    rx_rdy = 1'b1; rx_data = 8'h0C;
    #1;
    checkOutput("bnd_no_timeout", 32'(timeout_err), 32'd0);
    tick();
    checkOutput("bnd_cmd", 32'({cmd_rdy, cmd_op, cmd_data}), 32'h1_0A_0B0C);
    checkOutput("bnd_state_idle", 32'(dut.state_q), 32'(IDLE));
    endByte();
    doReset();

    // Reset mid-packet
    applyStimulus(8'h11);
    applyStimulus(8'h22);
    rst_n = 1'b0;
    #1;
    checkOutput("mid_rst_no_err", 32'(timeout_err), 32'd0);
    tick();
    checkOutput("mid_rst_state", 32'(dut.state_q), 32'(IDLE));
    rst_n = 1'b1;
    highs = 0;
    for (int i = 0; i < 60; i++) begin
      if (timeout_err) highs++;
      tick();
    end
    checkOutput("mid_rst_no_late_err", 32'(highs), 32'd0);
    applyStimulus(8'h33);
    applyStimulus(8'h44);
    applyStimulus(8'h55);
    checkOutput("mid_rst_fresh_cmd", 32'({cmd_rdy, cmd_op, cmd_data}), 32'h1_33_4455);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
